// File: rtl/codec_i2s_tx_if.sv
// Upstream sample-pair handshake for the I2S transmitter.
// The producer drives a left/right pair with valid, and the transmitter returns ready.
interface codec_i2s_tx_if #(
  parameter int unsigned ARRAY_WIDTH = 20
);
  logic [ARRAY_WIDTH-1:0] l_fpga_to_codec;
  logic [ARRAY_WIDTH-1:0] r_fpga_to_codec;
  logic                   sample_valid;
  logic                   sample_ready;

  modport master (
    output l_fpga_to_codec,
    output r_fpga_to_codec,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  l_fpga_to_codec,
    input  r_fpga_to_codec,
    input  sample_valid,
    output sample_ready
  );
endinterface

// File: rtl/codec_i2s_tx.sv
// I2S transmitter.
// A single-entry holding register accepts L/R sample pairs. At each frame load the held
// pair, or zeros on underrun, moves into per-channel shift registers. The shift registers
// are then serialised MSB first, one sclk period after the lrck edge.
// sclk, lrck and sdata all come straight from flops, so the codec sees no glitches.
module codec_i2s_tx #(
  parameter int unsigned ARRAY_WIDTH = 20,
  parameter int unsigned SCLK_DIV    = 4,
  parameter int unsigned SLOT_BITS   = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable,
  codec_i2s_tx_if.slave bus,
  output logic          sclk,
  output logic          lrck,
  output logic          sdata,
  output logic          frame_start,
  output logic          underrun,
  output logic [7:0]    underrun_count
);

  localparam int unsigned FrameBits = 2 * SLOT_BITS;
  localparam int unsigned DivW      = $clog2(SCLK_DIV);
  localparam int unsigned BitW      = $clog2(FrameBits);

  localparam logic [DivW-1:0] DivMax   = DivW'(SCLK_DIV - 1);
  localparam logic [DivW-1:0] DivHalf  = DivW'(SCLK_DIV / 2);
  localparam logic [BitW-1:0] BitMax   = BitW'(FrameBits - 1);
  localparam logic [BitW-1:0] SlotBits = BitW'(SLOT_BITS);
  localparam logic [BitW-1:0] WidthPos = BitW'(ARRAY_WIDTH);

  logic [DivW-1:0]        div_q, div_d;
  logic [BitW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                   sclk_q, sclk_d;
  logic                   lrck_q, lrck_d;
  logic                   sdata_q, sdata_d;
  logic                   frame_start_q, frame_start_d;
  logic                   underrun_q, underrun_d;
  logic [7:0]             underrun_count_q, underrun_count_d;
  logic                   full_q, full_d;
  logic [ARRAY_WIDTH-1:0] hold_l_q, hold_l_d;
  logic [ARRAY_WIDTH-1:0] hold_r_q, hold_r_d;
  logic [ARRAY_WIDTH-1:0] l_shift_q, l_shift_d;
  logic [ARRAY_WIDTH-1:0] r_shift_q, r_shift_d;

  logic            div_wrap;
  logic            load;
  logic            accept;
  logic [BitW-1:0] slot_pos;
  logic            in_data;

  assign bus.sample_ready = ~full_q;
  assign sclk             = sclk_q;
  assign lrck             = lrck_q;
  assign sdata            = sdata_q;
  assign frame_start      = frame_start_q;
  assign underrun         = underrun_q;
  assign underrun_count   = underrun_count_q;

  // Frame timing: counters, load detection and registered sclk/lrck.
  // Idle parks both counters at their maximum, so the first enabled cycle is a load.
  always_comb begin
    div_wrap = (div_q == DivMax);
    load     = enable && div_wrap && (bit_cnt_q == BitMax);
    accept   = bus.sample_valid && !full_q;

    if (!enable) begin
      div_d     = DivMax;
      bit_cnt_d = BitMax;
    end else if (div_wrap) begin
      div_d     = '0;
      bit_cnt_d = (bit_cnt_q == BitMax) ? '0 : bit_cnt_q + 1'b1;
    end else begin
      div_d     = div_q + 1'b1;
      bit_cnt_d = bit_cnt_q;
    end

    sclk_d = enable && (div_d >= DivHalf);
    lrck_d = enable && (bit_cnt_d >= SlotBits);

    slot_pos = lrck_d ? (bit_cnt_d - SlotBits) : bit_cnt_d;
    in_data  = (slot_pos != '0) && (slot_pos <= WidthPos);
  end

  // Serial data path: load at frame start, then shift one bit per sclk falling edge.
  always_comb begin
    l_shift_d = l_shift_q;
    r_shift_d = r_shift_q;
    sdata_d   = sdata_q;
    if (!enable) begin
      l_shift_d = '0;
      r_shift_d = '0;
      sdata_d   = 1'b0;
    end else if (load) begin
      l_shift_d = full_q ? hold_l_q : '0;
      r_shift_d = full_q ? hold_r_q : '0;
      sdata_d   = 1'b0;
    end else if (div_wrap) begin
      sdata_d = 1'b0;
      if (in_data) begin
        if (lrck_d) begin
          sdata_d   = r_shift_q[ARRAY_WIDTH-1];
          r_shift_d = r_shift_q << 1;
        end else begin
          sdata_d   = l_shift_q[ARRAY_WIDTH-1];
          l_shift_d = l_shift_q << 1;
        end
      end
    end
  end

  // Holding register and status pulses.
  // Accept and consume are mutually exclusive, because accept needs !full and consume needs full.
  always_comb begin
    full_d   = full_q;
    hold_l_d = hold_l_q;
    hold_r_d = hold_r_q;
    if (load && full_q) begin
      full_d = 1'b0;
    end
    if (accept) begin
      full_d   = 1'b1;
      hold_l_d = bus.l_fpga_to_codec;
      hold_r_d = bus.r_fpga_to_codec;
    end

    frame_start_d    = load;
    underrun_d       = load && !full_q;
    underrun_count_d = underrun_count_q;
    if (underrun_d && (underrun_count_q != 8'hFF)) begin
      underrun_count_d = underrun_count_q + 8'd1;
    end
  end

  // State registers, async active-low reset into the idle state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_q            <= DivMax;
      bit_cnt_q        <= BitMax;
      sclk_q           <= 1'b0;
      lrck_q           <= 1'b0;
      sdata_q          <= 1'b0;
      frame_start_q    <= 1'b0;
      underrun_q       <= 1'b0;
      underrun_count_q <= 8'd0;
      full_q           <= 1'b0;
      hold_l_q         <= '0;
      hold_r_q         <= '0;
      l_shift_q        <= '0;
      r_shift_q        <= '0;
    end else begin
      div_q            <= div_d;
      bit_cnt_q        <= bit_cnt_d;
      sclk_q           <= sclk_d;
      lrck_q           <= lrck_d;
      sdata_q          <= sdata_d;
      frame_start_q    <= frame_start_d;
      underrun_q       <= underrun_d;
      underrun_count_q <= underrun_count_d;
      full_q           <= full_d;
      hold_l_q         <= hold_l_d;
      hold_r_q         <= hold_r_d;
      l_shift_q        <= l_shift_d;
      r_shift_q        <= r_shift_d;
    end
  end

endmodule

// File: tb/tb_codec_i2s_tx.sv
// Bench for codec_i2s_tx (ARRAY_WIDTH=20, SCLK_DIV=4, SLOT_BITS=32, 256 clocks per frame).
// The model tracks the position inside the frame and the pair being sent, and derives the
// expected sclk/lrck/sdata from that position.
module tb_codec_i2s_tx;

  localparam int Aw    = 20;
  localparam int Frame = 256;

  logic       clock;
  logic       reset;
  logic       enable;
  logic       sclk, lrck, sdata, frame_start, underrun;
  logic [7:0] underrun_count;

  int checks = 0;
  int errors = 0;

  codec_i2s_tx_if #(.ARRAY_WIDTH(Aw)) bus ();

  codec_i2s_tx #(
    .ARRAY_WIDTH(Aw),
    .SCLK_DIV   (4),
    .SLOT_BITS  (32)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .bus           (bus),
    .sclk          (sclk),
    .lrck          (lrck),
    .sdata         (sdata),
    .frame_start   (frame_start),
    .underrun      (underrun),
    .underrun_count(underrun_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: frame position (-1 = idle), one-entry buffer, pair on the wire.
  int          m_pos;
  bit          m_full;
  logic [19:0] m_hold_l, m_hold_r, m_cur_l, m_cur_r;
  logic        e_sclk, e_lrck, e_sdata, e_fs, e_ur;
  logic [7:0]  e_cnt;
  bit          m_acc, m_ld, m_old_full;
  int          m_bit, m_k;
  logic [19:0] m_smp;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_pos    = -1;
      m_full   = 1'b0;
      m_hold_l = '0;
      m_hold_r = '0;
      m_cur_l  = '0;
      m_cur_r  = '0;
      e_sclk   = 1'b0;
      e_lrck   = 1'b0;
      e_sdata  = 1'b0;
      e_fs     = 1'b0;
      e_ur     = 1'b0;
      e_cnt    = 8'd0;
    end else begin
      m_old_full = m_full;
      m_acc      = bus.sample_valid && !m_old_full;
      m_ld       = enable && (m_pos < 0 || m_pos == Frame - 1);
      e_fs       = m_ld;
      e_ur       = m_ld && !m_old_full;
      if (e_ur && e_cnt != 8'd255) e_cnt = e_cnt + 8'd1;
      if (m_ld) begin
        m_cur_l = m_old_full ? m_hold_l : 20'h0;
        m_cur_r = m_old_full ? m_hold_r : 20'h0;
        m_full  = 1'b0;
      end
      if (!enable) m_pos = -1;
      else if (m_ld) m_pos = 0;
      else m_pos = m_pos + 1;
      if (m_acc) begin
        m_hold_l = bus.l_fpga_to_codec;
        m_hold_r = bus.r_fpga_to_codec;
        m_full   = 1'b1;
      end
      if (m_pos < 0) begin
        e_sclk  = 1'b0;
        e_lrck  = 1'b0;
        e_sdata = 1'b0;
      end else begin
        m_bit   = m_pos / 4;
        m_k     = m_bit % 32;
        e_sclk  = (m_pos % 4) >= 2;
        e_lrck  = m_bit >= 32;
        m_smp   = e_lrck ? m_cur_r : m_cur_l;
        e_sdata = (m_k >= 1 && m_k <= Aw) ? m_smp[Aw-m_k] : 1'b0;
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (reset === 1'b1) begin
      chk("sclk", 64'(sclk), 64'(e_sclk));
      chk("lrck", 64'(lrck), 64'(e_lrck));
      chk("sdata", 64'(sdata), 64'(e_sdata));
      chk("frame_start", 64'(frame_start), 64'(e_fs));
      chk("underrun", 64'(underrun), 64'(e_ur));
      chk("underrun_count", 64'(underrun_count), 64'(e_cnt));
      chk("sample_ready", 64'(bus.sample_ready), 64'(!m_full));
    end
  end

  // Offer a pair and hold valid until it is taken; returns at the negedge after acceptance.
  task automatic send_pair(input logic [19:0] l, input logic [19:0] r);
    int n;
    n = 0;
    bus.l_fpga_to_codec = l;
    bus.r_fpga_to_codec = r;
    bus.sample_valid    = 1'b1;
    while (bus.sample_ready !== 1'b1 && n < 600) begin
      @(negedge clock);
      n++;
    end
    if (bus.sample_ready !== 1'b1) chk("accept timeout", 64'(bus.sample_ready), 64'd1);
    @(negedge clock);
    bus.sample_valid = 1'b0;
  endtask

  task automatic wait_fs(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (frame_start !== 1'b1 && n < 600);
    if (frame_start !== 1'b1) chk({name, " frame_start timeout"}, 64'(frame_start), 64'd1);
  endtask

  // Capture one whole frame (sdata in the middle of each sclk high phase) and compare it
  // against the literal layout: zero bit, 20 data bits MSB first, 11 zero bits, per slot.
  task automatic capture_frame(input string name, input logic [19:0] l, input logic [19:0] r,
                               input logic exp_ur);
    logic [63:0] got, want;
    got = '0;
    wait_fs(name);
    chk({name, " underrun at load"}, 64'(underrun), 64'(exp_ur));
    for (int j = 0; j < Frame; j++) begin
      if (j % 4 == 2) got[63 - j / 4] = sdata;
      if (j < Frame - 1) @(negedge clock);
    end
    want = {1'b0, l, 11'b0, 1'b0, r, 11'b0};
    chk(name, got, want);
  endtask

  task automatic chk_idle_outputs(input string name);
    chk({name, " sclk"}, 64'(sclk), 64'd0);
    chk({name, " lrck"}, 64'(lrck), 64'd0);
    chk({name, " sdata"}, 64'(sdata), 64'd0);
  endtask

  initial begin
    reset               = 1'b0;
    enable              = 1'b0;
    bus.sample_valid    = 1'b0;
    bus.l_fpga_to_codec = '0;
    bus.r_fpga_to_codec = '0;

    // Reset state before any clock edge.
    #2;
    chk_idle_outputs("reset");
    chk("reset sample_ready", 64'(bus.sample_ready), 64'd1);
    chk("reset underrun_count", 64'(underrun_count), 64'd0);
    chk("reset frame_start", 64'(frame_start), 64'd0);

    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);

    // Handshake works while idle; the pair goes out in the frame of the first load.
    send_pair(20'hA5A5A, 20'h5A5A5);
    chk("held ready low", 64'(bus.sample_ready), 64'd0);
    enable = 1'b1;
    capture_frame("frame A5A5A/5A5A5", 20'hA5A5A, 20'h5A5A5, 1'b0);

    // Back-to-back pairs go out in consecutive frames without underrun.
    repeat (10) @(negedge clock);
    fork
      begin
        send_pair(20'h12345, 20'hFEDCB);
        send_pair(20'h80001, 20'h7FFFE);
      end
      begin
        capture_frame("frame P1", 20'h12345, 20'hFEDCB, 1'b0);
        capture_frame("frame P2", 20'h80001, 20'h7FFFE, 1'b0);
      end
    join

    // Drop enable at bit_cnt=10 with a pair held, then re-enable.
    wait_fs("pre-abort");
    send_pair(20'hFFFFF, 20'h00001);
    repeat (39) @(negedge clock);
    enable = 1'b0;
    @(negedge clock);
    chk_idle_outputs("abort");
    repeat (5) @(negedge clock);
    enable = 1'b1;
    capture_frame("frame after re-enable", 20'hFFFFF, 20'h00001, 1'b0);

    // Accept in the same cycle as an empty load: underrun still fires, and the pair stays held.
    send_pair(20'hC3C3C, 20'h3C3C3);
    chk("same-cycle accept underrun", 64'(underrun), 64'd1);
    chk("same-cycle accept frame_start", 64'(frame_start), 64'd1);
    chk("same-cycle accept held", 64'(bus.sample_ready), 64'd0);

    // Asynchronous reset at bit_cnt=40 (lrck high) discards everything.
    repeat (161) @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    chk_idle_outputs("mid-frame reset");
    chk("mid-frame reset ready", 64'(bus.sample_ready), 64'd1);
    chk("mid-frame reset count", 64'(underrun_count), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    wait_fs("post-reset");
    chk("post-reset underrun", 64'(underrun), 64'd1);
    chk("post-reset count", 64'(underrun_count), 64'd1);

    // Starved link: one underrun per frame, and the count saturates at 255.
    for (int f = 0; f < 256; f++) wait_fs("starved");
    chk("saturated underrun", 64'(underrun), 64'd1);
    chk("saturated count", 64'(underrun_count), 64'd255);

    repeat (4) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/codec_i2s_tx.md
CODEC_I2S_TX -- requirements
Module: codec_i2s_tx

Interface
REQ-001 Parameter ARRAY_WIDTH, 20, sample width per channel (two's complement).
REQ-002 Parameter SCLK_DIV, 4, clock cycles per sclk period; even, >=2.
REQ-003 Parameter SLOT_BITS, 32, sclk periods per channel slot; >= ARRAY_WIDTH+1.
REQ-004 clock  input  1  sole clock; all flops rising-edge.
REQ-005 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 enable  input  1  1 = serial link running; 0 = link idle.
REQ-007 l_fpga_to_codec  input  ARRAY_WIDTH  left sample, valid with sample_valid.
REQ-008 r_fpga_to_codec  input  ARRAY_WIDTH  right sample, valid with sample_valid.
REQ-009 sample_valid  input  1  upstream offers an L/R sample pair.
REQ-010 sample_ready  output  1  holding register empty; pair accepted when valid&&ready.
REQ-011 sclk  output  1  serial bit clock to codec.
REQ-012 lrck  output  1  word select; 0 = left slot, 1 = right slot.
REQ-013 sdata  output  1  serial data to codec, MSB first.
REQ-014 frame_start  output  1  one-cycle pulse at each frame load.
REQ-015 underrun  output  1  one-cycle pulse when a frame loads with holding register empty.
REQ-016 underrun_count  output  8  saturating count of underrun pulses.

Function
REQ-017 div counter 0..SCLK_DIV-1 increments every enabled cycle, wraps to 0.
REQ-018 bit_cnt 0..2*SLOT_BITS-1 increments when div wraps; wraps to 0.
REQ-019 While enabled: sclk=1 iff div>=SCLK_DIV/2; lrck=1 iff bit_cnt>=SLOT_BITS; all three serial outputs registered, glitch-free.
REQ-020 Slot bit k (k = bit_cnt mod SLOT_BITS): sdata=0 at k=0; sdata=sample[ARRAY_WIDTH-k] for 1<=k<=ARRAY_WIDTH; sdata=0 for k>ARRAY_WIDTH.
REQ-021 sdata changes only on sclk falling edge (div wrap); stable across sclk rising edge.
REQ-022 Holding register: L/R pair plus full flag; sample_ready = !full; accept sets full.
REQ-023 Frame load event: enabled cycle where div=SCLK_DIV-1 and bit_cnt=2*SLOT_BITS-1, or first enabled cycle after idle.
REQ-024 At load: full=1 -> shift registers take held pair, full cleared; full=0 -> shift registers take zeros, underrun pulses.
REQ-025 frame_start pulses on every load event, aligned with bit_cnt becoming 0.
REQ-026 Accept in same cycle as an empty-load: underrun still pulses; accepted pair stays held for next frame (no bypass).
REQ-027 Latency: accepted pair appears on sdata in the frame following the next load event; at most one pair buffered.
REQ-028 underrun_count increments per underrun pulse; holds at 255.
REQ-029 enable=0: next edge forces sclk=lrck=sdata=0, div=SCLK_DIV-1, bit_cnt=2*SLOT_BITS-1, shift registers cleared; holding register and handshake keep operating.
REQ-030 enable deassert mid-frame aborts frame immediately; partial frame is not resumed.

Reset
REQ-031 reset=0 asynchronously clears: sclk, lrck, sdata, frame_start, underrun = 0; underrun_count = 0; full=0 (sample_ready=1); counters to idle values of REQ-029; shift and holding data = 0.
REQ-032 After reset release, first enabled cycle is a load event per REQ-023.
REQ-033 Reset asserted mid-frame or mid-handshake discards all in-flight data.

Verification (ARRAY_WIDTH=20, SCLK_DIV=4, SLOT_BITS=32; frame = 256 clocks)
REQ-034 Reset: hold reset=0 -> sample_ready=1, sclk=lrck=sdata=0, underrun_count=0, with no clock edge required.
REQ-035 Pair L=20'hA5A5A, R=20'h5A5A5, then enable=1 -> following frame: lrck=0 slot bits 1..20 = A5A5A MSB first, bits 0, 21..31 = 0; lrck=1 slot carries 5A5A5 likewise.
REQ-036 enable=1, no samples -> all-zero frames, underrun pulses once per frame; after 300 frames underrun_count=255.
REQ-037 Back-to-back valid pairs P1, P2 -> P1 accepted, ready=0 until next load, P2 accepted the cycle after load; P1 and P2 sent in consecutive frames with no underrun.
REQ-038 enable dropped at bit_cnt=10 with pair held -> sclk/lrck/sdata=0 next cycle; re-enable -> immediate load, frame_start pulse, held pair transmitted from bit_cnt 0.
REQ-039 reset=0 asserted at bit_cnt=40 -> all outputs cleared asynchronously; after release with enable=1, empty-load underrun pulse and underrun_count=1.
